div_scheduler: RTL and testbench

//  Shares one 16/16 divider core among N_REQ requesters (CPU peripheral port, DMA, accel).

---
 rtl/div_sched_pkg.sv | 22 ++
 rtl/div_scheduler_if.sv | 40 ++++
 rtl/div_scheduler_rr_arbiter.sv | 31 +++
 rtl/div_scheduler.sv | 153 +++++++++++++++
 tb/tb_div_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider scheduler: FSM state encoding,
// default widths, timeout default and the divide-by-zero result pattern.
package div_sched_pkg;

    localparam int N_REQ_DEF   = 2;
    localparam int W_OP_DEF    = 16;
    localparam int W_RES_DEF   = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int W_CNT       = 8;   // timeout counter width

    // Result returned for a zero divisor (all ones).
    localparam logic [W_RES_DEF-1:0] DIV0_RESULT = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CLEAR = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/div_scheduler_if.sv
// Bus bundle between the requesters / divider core and the scheduler.
//   req_valid/req_a/req_b/req_ready : requester handshake (slot i at [i*W_OP +: W_OP])
//   rsp_valid/rsp_data/rsp_err      : one-hot response pulse back to the owner
//   busy                            : scheduler not idle
//   div_init/div_op_a/div_op_b      : launch strobe and operands to the core
//   div_done/div_result             : core completion level and result
// master = the environment (requesters + core), slave = the scheduler.
interface div_scheduler_if
    import div_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W_OP  = W_OP_DEF,
    parameter int W_RES = W_RES_DEF
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*W_OP-1:0] req_a;
    logic [N_REQ*W_OP-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic [W_RES-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  div_init;
    logic [W_OP-1:0]       div_op_a;
    logic [W_OP-1:0]       div_op_b;
    logic                  div_done;
    logic [W_RES-1:0]      div_result;

    modport master (
        output req_valid, req_a, req_b, div_done, div_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
               div_init, div_op_a, div_op_b
    );

    modport slave (
        input  req_valid, req_a, req_b, div_done, div_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
               div_init, div_op_a, div_op_b
    );
endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin arbiter (combinational).
//   req     : request vector
//   ptr     : highest-priority slot; search wraps from ptr upward
//   gnt     : one-hot grant of first request at/after ptr, zero if none
//   gnt_idx : index of the granted slot (0 when none)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
endmodule

// File: rtl/div_scheduler.sv
// Shares one divider core among N_REQ requesters.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : requester handshake, response and div core signals
// Flow: IDLE -> START -> CLEAR -> BUSY -> RESP -> IDLE, or IDLE -> RESP for
// a zero divisor. CLEAR waits for the core to drop a done left over from a
// previous operation so an old result is never taken as the new one.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W_OP    = W_OP_DEF,
    parameter int W_RES   = W_RES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    div_scheduler_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT - 1);
    // All-ones pattern stretched to the configured result width.
    localparam logic [W_RES-1:0] DIV0_FILL = {W_RES{DIV0_RESULT[0]}};

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic [W_OP-1:0]   op_a_q, op_a_d;
    logic [W_OP-1:0]   op_b_q, op_b_d;
    logic [W_RES-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ-1:0]  rsp_valid;
    logic              div_init;
    logic [W_OP-1:0]   sel_a, sel_b;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_a = bus.req_a[int'(gnt_idx)*W_OP +: W_OP];
    assign sel_b = bus.req_b[int'(gnt_idx)*W_OP +: W_OP];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        div_init   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated so no grant is shown while reset is held.
                if (!reset) req_ready = gnt;
                // gnt only ever covers valid requests, so any grant is an accept.
                if (|gnt) begin
                    owner_d = gnt_idx;
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                    if (sel_b == '0) begin
                        rsp_data_d = DIV0_FILL;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                div_init = 1'b1;
                cnt_d    = '0;
                state_d  = S_CLEAR;
            end
            S_CLEAR: begin
                // Exits take precedence over the timeout check; >= covers
                // entering BUSY with the counter already past the limit.
                if (!bus.div_done) begin
                    cnt_d   = cnt_q + W_CNT'(1);
                    state_d = S_BUSY;
                end else if (cnt_q >= CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            S_BUSY: begin
                if (bus.div_done) begin
                    rsp_data_d = bus.div_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    // Core is left running; the next START re-inits it.
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            S_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.div_init  = div_init;
    assign bus.div_op_a  = op_a_q;
    assign bus.div_op_b  = op_b_q;
endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider core.
// Core result format: {quotient[15:0], remainder[15:0]}, ready LAT cycles
// after init. Latencies are counted in cycles from the START cycle.
module tb_div_scheduler;
    localparam int LAT = 10;
    localparam int M_NORM = 0, M_HANG = 1, M_STALE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_scheduler_if #(.N_REQ(2), .W_OP(16), .W_RES(32)) bus ();

    div_scheduler #(.N_REQ(2), .W_OP(16), .W_RES(32), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- divider core model ----------------
    int          mode = M_NORM;
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0;
    int          m_cnt = 0;
    int          m_stale = 0;
    assign bus.div_done   = m_done;
    assign bus.div_result = m_res;

    always @(posedge clk) begin
        if (bus.div_init) begin
            m_cnt <= 0;
            m_stale <= 0;
            if (mode == M_NORM) begin
                m_done <= 1'b0; m_cnt <= LAT;
            end else if (mode == M_HANG) begin
                m_done <= 1'b0;
            end else begin
                m_done <= 1'b1; m_res <= 32'hDEAD_BEEF; m_stale <= 3;
            end
        end else if (m_stale != 0) begin
            m_stale <= m_stale - 1;
            if (m_stale == 1) begin m_done <= 1'b0; m_cnt <= LAT; end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= {bus.div_op_a / bus.div_op_b, bus.div_op_a % bus.div_op_b};
            end
        end
    end

    // ---------------- event monitors ----------------
    int init_cnt = 0;
    int rsp_cnt  = 0;
    always @(posedge clk) begin
        if (bus.div_init) init_cnt <= init_cnt + 1;
        if (|bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE with requests already driven. Runs one
    // transaction and returns at the negedge of the cycle after RESP.
    task automatic do_op(input string tag, input logic [1:0] g,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] d, input logic e,
                         input int lat, input bit drop);
        int n0;
        int n;
        #1;
        chk({tag, "_gnt"}, 32'(bus.req_ready), 32'(g));
        n0 = init_cnt;
        @(negedge clk);
        if (drop) bus.req_valid = '0;
        chk({tag, "_op_a"}, 32'(bus.div_op_a), 32'(a));
        chk({tag, "_op_b"}, 32'(bus.div_op_b), 32'(b));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_rdy0"}, 32'(bus.req_ready), 32'd0);
        if (b != 16'd0) chk({tag, "_init"}, 32'(bus.div_init), 32'd1);
        n = 0;
        while (bus.rsp_valid == '0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(g));
        chk({tag, "_data"}, bus.rsp_data, d);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e));
        chk({tag, "_ninit"}, 32'(init_cnt - n0), (b != 16'd0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    initial begin
        int r0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset state
        @(negedge clk);
        chk("rst_rdy",  32'(bus.req_ready), 32'd0);
        chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_init", 32'(bus.div_init), 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        chk("rst_op_a", 32'(bus.div_op_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request: 100/7 = 14 r 2
        set_req(0, 16'd100, 16'd7);
        do_op("single", 2'b01, 16'd100, 16'd7, 32'h000E_0002, 1'b0, LAT + 2, 1'b1);

        // Round robin with both valid from reset; pointer wraps to req0
        reset = 1'b1;
        set_req(0, 16'd200, 16'd10);
        set_req(1, 16'd1000, 16'd33);
        @(negedge clk);
        #1;
        chk("rst_gate_rdy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("rr1", 2'b01, 16'd200,  16'd10, 32'h0014_0000, 1'b0, LAT + 2, 1'b0);
        do_op("rr2", 2'b10, 16'd1000, 16'd33, 32'h001E_000A, 1'b0, LAT + 2, 1'b0);
        do_op("rr3", 2'b01, 16'd200,  16'd10, 32'h0014_0000, 1'b0, LAT + 2, 1'b0);
        bus.req_valid = '0;
        @(negedge clk);

        // Stale done held 3 cycles after init: only the fresh result counts
        mode = M_STALE;
        set_req(0, 16'd81, 16'd9);
        do_op("stale", 2'b01, 16'd81, 16'd9, 32'h0009_0000, 1'b0, LAT + 5, 1'b1);

        // Core never finishes: timeout after 255 cycles in CLEAR+BUSY
        mode = M_HANG;
        set_req(0, 16'd1234, 16'd5);
        do_op("tmo", 2'b01, 16'd1234, 16'd5, 32'h0000_0000, 1'b1, 256, 1'b1);
        mode = M_NORM;

        // Divide by zero on req1, held valid: back-to-back grant at T+2
        set_req(1, 16'd5, 16'd0);
        do_op("div0", 2'b10, 16'd5, 16'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        chk("div0_b2b", 32'(bus.req_ready), 32'd2);
        bus.req_valid = '0;
        @(negedge clk);

        // Reset during BUSY: outputs clear at once, no response afterwards
        set_req(0, 16'd60000, 16'd250);
        #1;
        chk("rbusy_gnt", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        chk("rbusy_busy_pre", 32'(bus.busy), 32'd1);
        bus.req_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("rbusy_busy", 32'(bus.busy), 32'd0);
        chk("rbusy_init", 32'(bus.div_init), 32'd0);
        chk("rbusy_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rbusy_rdy",  32'(bus.req_ready), 32'd0);
        chk("rbusy_data", bus.rsp_data, 32'd0);
        chk("rbusy_err",  32'(bus.rsp_err), 32'd0);
        chk("rbusy_op_a", 32'(bus.div_op_a), 32'd0);
        chk("rbusy_op_b", 32'(bus.div_op_b), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        reset = 1'b0;
        r0 = rsp_cnt;
        repeat (20) @(negedge clk);
        chk("rbusy_norsp", 32'(rsp_cnt - r0), 32'd0);
        set_req(0, 16'd65535, 16'd256);
        set_req(1, 16'd9, 16'd3);
        do_op("post_rst", 2'b01, 16'd65535, 16'd256, 32'h00FF_00FF, 1'b0, LAT + 2, 1'b0);
        bus.req_valid = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
